// File: rtl/cordic_ctrl_if.sv
// Valid/ready stream bundle carrying one packed data word.
// master drives valid/data; slave drives ready.
interface cordic_ctrl_if #(
  parameter int W = 28
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/cordic_ctrl.sv
// Sequencer for cordic_core: buffers one {x,y,angle} operand, runs N micro-rotations, returns data_r.
// Ports: clk, rst (async low), s (operand stream in), m (result stream out), data_w/c/cnt/data_r (core side), busy.
module cordic_ctrl #(
  parameter int B  = 14,
  parameter int N  = 7,
  parameter int CW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  cordic_ctrl_if.slave   s,
  cordic_ctrl_if.master  m,
  output logic [2*B-1:0] data_w,
  output logic [8:1]     c,
  output logic [CW-1:0]  cnt,
  input  logic [2*B-1:0] data_r,
  output logic           busy
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    HOLD,
    WR_X,
    WR_Y
  } state_t;

  localparam logic [8:1] C_IDLE = 8'h00;
  localparam logic [8:1] C_LOAD = 8'h83;
  localparam logic [8:1] C_ITER = 8'h02;
  localparam logic [8:1] C_HOLD = 8'h00;
  localparam logic [8:1] C_WR_X = 8'h20;
  localparam logic [8:1] C_WR_Y = 8'h50;

  localparam logic [CW-1:0] CNT_PEN  = CW'(N - 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_t state;
  logic   buf_full;
  logic   s_fire;
  logic   m_fire;
  logic   out_free;

  // The buffer empties during LOAD, so a new operand
  // can land on the same edge the core takes the old one.
  assign s.ready  = !buf_full || (state == LOAD);
  assign s_fire   = s.valid && s.ready;
  assign m_fire   = m.valid && m.ready;
  // Core output registers may only be rewritten once
  // the pending result is gone or leaving this cycle.
  assign out_free = !m.valid || m.ready;
  assign m.data   = data_r;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      buf_full <= 1'b0;
      data_w   <= '0;
      cnt      <= '0;
      c        <= C_IDLE;
      m.valid  <= 1'b0;
    end else begin
      if (s_fire) begin
        data_w   <= s.data;
        buf_full <= 1'b1;
      end else if (state == LOAD) begin
        buf_full <= 1'b0;
      end

      if (state == WR_Y) begin
        m.valid <= 1'b1;
      end else if (m_fire) begin
        m.valid <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (buf_full) begin
            state <= LOAD;
            c     <= C_LOAD;
            cnt   <= '0;
          end
        end
        LOAD: begin
          state <= ITER;
          c     <= C_ITER;
          cnt   <= '0;
        end
        ITER: begin
          if (cnt == CNT_PEN) begin
            // Last stage is combinational in the core;
            // it is captured straight into x/y out.
            cnt <= CNT_LAST;
            if (out_free) begin
              state <= WR_X;
              c     <= C_WR_X;
            end else begin
              state <= HOLD;
              c     <= C_HOLD;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          if (out_free) begin
            state <= WR_X;
            c     <= C_WR_X;
          end
        end
        WR_X: begin
          state <= WR_Y;
          c     <= C_WR_Y;
        end
        WR_Y: begin
          cnt <= '0;
          if (buf_full) begin
            state <= LOAD;
            c     <= C_LOAD;
          end else begin
            state <= IDLE;
            c     <= C_IDLE;
          end
        end
        default: begin
          state <= IDLE;
          c     <= C_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/cordic_ctrl.md
Name: cordic_ctrl

Overview:
- Sequencing controller directly upstream of cordic_core.
- Accepts packed {x, y, angle} words over a valid/ready input, holds one in a single-entry buffer, and drives data_w, c[8:1] and cnt to run N micro-rotations.
- Returns the core's data_r result over a valid/ready output.
- Next operand may be accepted while the current rotation runs; core output registers are never overwritten before the pending result is taken.

Parameters:
- B, 14, half-word width; data words are 2*B bits.
- N, 7, number of CORDIC iterations (N >= 2).
- CW, $clog2(N), width of cnt.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- s_valid  input  1  operand valid.
- s_ready  output  1  operand accepted when s_valid && s_ready.
- s_data  input  2*B  packed operand {x, y, angle}.
- data_w  output  2*B  to core; buffer contents.
- c  output  8 ([8:1])  core control: c[1] load select, c[2] working-register enable, c[5] result mux (1 = right/y), c[6] x-out enable, c[7] y-out enable, c[8] angle-register enable. c[3], c[4] are always 0.
- cnt  output  CW  iteration index to core.
- data_r  input  2*B  core result.
- m_valid  output  1  result valid.
- m_ready  input  1  result consumed when m_valid && m_ready.
- m_data  output  2*B  equals data_r (combinational passthrough).
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst low, async): state=IDLE, buffer empty, cnt=0, m_valid=0, data_w=0. c decodes to 8'h00.
- Buffer:
  - s_ready = !buf_full || (state==LOAD).
  - On accept, s_data is captured into the buffer and buf_full is set.
  - buf_full clears at the end of the LOAD cycle unless a new accept occurs in that same cycle; in that case it stays set with the new data.
  - data_w always presents the buffer register.
- States and c[8:1] (Moore, decoded from state; c written as c[8:1] hex):
  - IDLE: c=8'h00.
  - LOAD: c=8'h83 (c[8], c[2], c[1]); cnt=0.
  - ITER: c=8'h02; cnt steps 0..N-2.
  - HOLD: c=8'h00; cnt=N-1.
  - WR_X: c=8'h20 (c[6]); c[5]=0; cnt=N-1.
  - WR_Y: c=8'h50 (c[7], c[5]); cnt=N-1.
- Transitions:
  - IDLE -> LOAD when buf_full.
  - LOAD -> ITER with cnt=0.
  - ITER: cnt increments each cycle. At cnt==N-2, set cnt=N-1 and go to WR_X if (!m_valid || m_ready), else to HOLD.
  - HOLD -> WR_X when (!m_valid || m_ready).
  - WR_X -> WR_Y.
  - WR_Y -> LOAD if buf_full, else IDLE.
- Iteration N-1 is not registered. WR_X and WR_Y capture the combinational final stage through the core's scaler while c[2]=0 holds the working registers.
- m_valid: set at the end of WR_Y. Cleared on m_valid && m_ready. If both coincide, set wins; this cannot occur because WR_X already requires m_valid to be clear or consumed.
- Latency: accept at edge E0 -> LOAD in cycle E0+2 -> m_valid high at E0+N+4 (N=7: 11 cycles), absent output stall.
- Back-to-back throughput is N+2 cycles per operation with continuous input and m_ready=1.
- A stalled output delays only WR_X; LOAD and ITER of the next operation proceed.
- No operand loss: s_ready deasserts while the buffer is full, except during LOAD.

Test Plan:
- Reset mid-ITER (rst low at cnt=3) -> immediately: c=8'h00, cnt=0, m_valid=0, s_ready=1, busy=0.
- Single op (N=7, s_data=28'h1234567, m_ready=1) -> data_w=28'h1234567 in LOAD (c=8'h83), six ITER cycles (c=8'h02, cnt 0..5), WR_X c=8'h20 cnt=6, WR_Y c=8'h50 cnt=6, m_valid at E0+11.
- Core model with x0=0x09B7, y0=0, angle bits 0101010 -> m_data matches the golden CORDIC model bit-exactly.
- Back-to-back 4 operands with s_valid held -> s_ready high only in LOAD while buffer full; results spaced 9 cycles apart; order preserved.
- m_ready=0 for 20 cycles with a second op queued -> second op reaches HOLD (c=8'h00, cnt=6); the first m_data stays stable; WR_X occurs the cycle after m_ready rises.
- Accept during LOAD of a previous op -> new data captured, buf_full stays 1, WR_Y -> LOAD directly.
